// File: rtl/data_mem_responder.sv
// Data-memory responder: accepts one load/store at a time, answers LATENCY+1 cycles after accept.
// Optional build macro DMEM_MISALIGN_ERR_EN turns misaligned accesses into errors instead of truncating them.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            we_q, we_d;
    logic [AW+1:0]   addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [2:0]      f3_q, f3_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            err_q, err_d;

    logic [31:0]     mem [DEPTH_WORDS];

    logic            unused_addr_hi;
    assign unused_addr_hi = ^req_addr[31:AW+2];

    // Access decode, all from the captured request
    logic            size_byte, size_half, size_word;
    logic            legal;
    logic            access_err;
    logic [1:0]      off;
    logic [AW-1:0]   word_idx;
    logic [31:0]     rd_word;
    logic [7:0]      byte_val;
    logic [15:0]     half_val;
    logic [31:0]     load_data;
    logic [3:0]      byte_en;
    logic [31:0]     wr_lanes;
    logic            mem_wr;

    always_comb begin
        size_byte = (f3_q[1:0] == 2'b00);
        size_half = (f3_q[1:0] == 2'b01);
        size_word = (f3_q[1:0] == 2'b10);
        if (we_q) begin
            legal = (f3_q[2] == 1'b0) && (f3_q[1:0] != 2'b11);
        end else begin
            legal = (f3_q[1:0] != 2'b11) && !(f3_q[2] && f3_q[1]);
        end
`ifdef DMEM_MISALIGN_ERR_EN
        access_err = !legal
                   || (size_half && addr_q[0])
                   || (size_word && (addr_q[1:0] != 2'b00));
        off        = addr_q[1:0];
`else
        access_err = !legal;
        if (size_word) begin
            off = 2'b00;
        end else if (size_half) begin
            off = {addr_q[1], 1'b0};
        end else begin
            off = addr_q[1:0];
        end
`endif
        word_idx = addr_q[AW+1:2];
        rd_word  = mem[word_idx];
    end

    always_comb begin
        case (off)
            2'd0:    byte_val = rd_word[7:0];
            2'd1:    byte_val = rd_word[15:8];
            2'd2:    byte_val = rd_word[23:16];
            default: byte_val = rd_word[31:24];
        endcase
        half_val = off[1] ? rd_word[31:16] : rd_word[15:0];

        // funct3[2] selects zero-extension (LBU/LHU)
        if (size_byte) begin
            load_data = f3_q[2] ? {24'b0, byte_val} : {{24{byte_val[7]}}, byte_val};
        end else if (size_half) begin
            load_data = f3_q[2] ? {16'b0, half_val} : {{16{half_val[15]}}, half_val};
        end else begin
            load_data = rd_word;
        end
    end

    always_comb begin
        if (size_byte) begin
            byte_en  = 4'b0001 << off;
            wr_lanes = {4{wdata_q[7:0]}};
        end else if (size_half) begin
            byte_en  = off[1] ? 4'b1100 : 4'b0011;
            wr_lanes = {2{wdata_q[15:0]}};
        end else begin
            byte_en  = 4'b1111;
            wr_lanes = wdata_q;
        end
        mem_wr = (state_q == S_RESP) && we_q && !access_err;
    end

    // Store commits on the edge leaving RESP; contents survive reset
    always_ff @(posedge clk) begin
        if (mem_wr) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (byte_en[i]) begin
                    mem[word_idx][i*8 +: 8] <= wr_lanes[i*8 +: 8];
                end
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        f3_d        = f3_q;
        rsp_valid_d = 1'b0;
        rdata_d     = '0;
        err_d       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    addr_d  = req_addr[AW+1:0];
                    wdata_d = req_wdata;
                    f3_d    = req_funct3;
                    if (LATENCY > 0) begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_INIT;
                    end else begin
                        state_d = S_RESP;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                // Response is registered here, so it appears one edge after RESP
                rsp_valid_d = 1'b1;
                err_d       = access_err;
                rdata_d     = (!we_q && !access_err) ? load_data : '0;
                state_d     = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            f3_q        <= '0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            f3_q        <= f3_d;
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
        end
    end

    assign req_ready = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized bench for data_mem_responder against a byte-lane reference model of the memory.
// Honours DMEM_MISALIGN_ERR_EN so the same bench covers both builds.
module tb_data_mem_responder;

    localparam int DEPTH = 1024;
    localparam int LAT   = 2;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_funct3;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;

    int          n_vec;
    int          n_err;
    logic [31:0] last_rdata;
    logic        last_err;
    logic [31:0] ref_mem [DEPTH];

    data_mem_responder #(
        .DEPTH_WORDS(DEPTH),
        .LATENCY    (LAT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_funct3 (req_funct3),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: memory as words, accesses as byte count + byte offset arithmetic
    function automatic void model_access(input bit we, input logic [31:0] addr,
                                         input logic [31:0] wd, input logic [2:0] f3,
                                         output logic [31:0] rd, output bit err);
        int unsigned nbytes;
        int unsigned off;
        int unsigned idx;
        logic [31:0] mask;
        logic [31:0] w;
        rd  = '0;
        err = 1'b0;
        case (f3)
            3'd0, 3'd4: nbytes = 1;
            3'd1, 3'd5: nbytes = 2;
            3'd2:       nbytes = 4;
            default:    nbytes = 0;
        endcase
        if (nbytes == 0 || (we && f3[2])) begin
            err = 1'b1;
            return;
        end
        off = addr % 4;
        if (off % nbytes != 0) begin
`ifdef DMEM_MISALIGN_ERR_EN
            err = 1'b1;
            return;
`else
            off = off - off % nbytes;
`endif
        end
        idx  = (addr / 4) % DEPTH;
        mask = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nbytes)) - 32'd1);
        if (we) begin
            ref_mem[idx] = (ref_mem[idx] & ~(mask << (8 * off))) | ((wd & mask) << (8 * off));
        end else begin
            w = (ref_mem[idx] >> (8 * off)) & mask;
            if (!f3[2] && nbytes < 4 && w[8 * nbytes - 1]) w = w | ~mask;
            rd = w;
        end
    endfunction

    task automatic do_req(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [2:0] f3, input string tag);
        logic [31:0] exp_rd;
        bit          exp_err;
        int          cycles;
        bit          got;
        model_access(we, addr, wd, f3, exp_rd, exp_err);
        req_valid  = 1'b1;
        req_we     = we;
        req_addr   = addr;
        req_wdata  = wd;
        req_funct3 = f3;
        check_eq({tag, "_ready"}, 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        cycles    = 0;
        got       = 1'b0;
        while (!got && cycles < 40) begin
            if (cycles <= LAT) begin
                check_eq({tag, "_busy"}, 32'(busy), 32'd1);
                // Spurious stores while busy must be ignored
                req_valid  = 1'($urandom_range(0, 1));
                req_we     = 1'b1;
                req_addr   = $urandom;
                req_wdata  = $urandom;
                req_funct3 = 3'b010;
            end else begin
                req_valid = 1'b0;
            end
            @(posedge clk);
            #1;
            cycles++;
            if (rsp_valid) got = 1'b1;
        end
        req_valid = 1'b0;
        check_eq({tag, "_lat"}, 32'(cycles), 32'(LAT + 1));
        check_eq({tag, "_rdata"}, rsp_rdata, exp_rd);
        check_eq({tag, "_err"}, 32'(rsp_err), 32'(exp_err));
        last_rdata = rsp_rdata;
        last_err   = rsp_err;
        @(posedge clk);
        #1;
        check_eq({tag, "_strobe"}, 32'(rsp_valid), 32'd0);
        check_eq({tag, "_idle_rdata"}, rsp_rdata, 32'd0);
        check_eq({tag, "_idle_err"}, 32'(rsp_err), 32'd0);
    endtask

    initial begin
        logic [31:0] up;
        int unsigned w;
        int unsigned off;
        n_vec      = 0;
        n_err      = 0;
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        req_funct3 = '0;
        #12;
        check_eq("rst_valid", 32'(rsp_valid), 32'd0);
        check_eq("rst_rdata", rsp_rdata, 32'd0);
        check_eq("rst_err",   32'(rsp_err), 32'd0);
        check_eq("rst_busy",  32'(busy), 32'd0);
        check_eq("rst_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        do_req(1'b1, 32'h10, 32'hDEAD_BEEF, 3'b010, "sw10");
        do_req(1'b0, 32'h10, 32'h0, 3'b010, "lw10");
        check_eq("lw10_val", last_rdata, 32'hDEAD_BEEF);
        do_req(1'b0, 32'h13, 32'h0, 3'b000, "lb13");
        check_eq("lb13_val", last_rdata, 32'hFFFF_FFDE);
        do_req(1'b0, 32'h13, 32'h0, 3'b100, "lbu13");
        check_eq("lbu13_val", last_rdata, 32'h0000_00DE);
        do_req(1'b0, 32'h10, 32'h0, 3'b001, "lh10");
        check_eq("lh10_val", last_rdata, 32'hFFFF_BEEF);
        do_req(1'b0, 32'h12, 32'h0, 3'b101, "lhu12");
        check_eq("lhu12_val", last_rdata, 32'h0000_DEAD);
        do_req(1'b1, 32'h11, 32'h0000_0055, 3'b000, "sb11");
        do_req(1'b0, 32'h10, 32'h0, 3'b010, "lw10b");
        check_eq("sb_merge", last_rdata, 32'hDEAD_55EF);
        do_req(1'b1, 32'h12, 32'h0000_1234, 3'b001, "sh12");
        do_req(1'b0, 32'h10, 32'h0, 3'b010, "lw10c");
        check_eq("sh_merge", last_rdata, 32'h1234_55EF);
        do_req(1'b0, 32'h12, 32'h0, 3'b010, "lw12");
`ifdef DMEM_MISALIGN_ERR_EN
        check_eq("lw12_val", last_rdata, 32'h0);
        check_eq("lw12_err", 32'(last_err), 32'd1);
`else
        check_eq("lw12_val", last_rdata, 32'h1234_55EF);
        check_eq("lw12_err", 32'(last_err), 32'd0);
`endif
        do_req(1'b1, 32'h1000, 32'h0000_0001, 3'b010, "sw1000");
        do_req(1'b0, 32'h0, 32'h0, 3'b010, "lw0");
        check_eq("alias_val", last_rdata, 32'h0000_0001);
        do_req(1'b0, 32'h4, 32'h0, 3'b011, "ld011");
        check_eq("f3_011_err", 32'(last_err), 32'd1);

        // Reset in WAIT discards a pending store
        do_req(1'b1, 32'h20, 32'h1111_1111, 3'b010, "sw20");
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_addr   = 32'h20;
        req_wdata  = 32'hAAAA_AAAA;
        req_funct3 = 3'b010;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check_eq("pre_rst_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        check_eq("mid_rst_busy",  32'(busy), 32'd0);
        check_eq("mid_rst_ready", 32'(req_ready), 32'd1);
        check_eq("mid_rst_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            check_eq("post_rst_valid", 32'(rsp_valid), 32'd0);
        end
        do_req(1'b0, 32'h20, 32'h0, 3'b010, "lw20");
        check_eq("lw20_prior", last_rdata, 32'h1111_1111);

        for (int unsigned i = 0; i < 32; i++) begin
            do_req(1'b1, 32'(i * 4), $urandom, 3'b010, "init");
        end
        for (int i = 0; i < 250; i++) begin
            up  = $urandom;
            w   = $urandom_range(0, 31);
            off = $urandom_range(0, 3);
            do_req(1'($urandom_range(0, 1)),
                   (up & 32'hFFFF_F000) | (32'(w) << 2) | 32'(off),
                   $urandom, 3'($urandom_range(0, 7)), "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024, memory depth in 32-bit words (power of two, 16..65536).
REQ-002 Parameter LATENCY, default 2, wait cycles between request accept and response (0..15).
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req_valid  input  1  the core's MEM stage presents an access.
REQ-006 req_ready  output  1  responder can accept; a transfer occurs when req_valid&req_ready at a rising edge.
REQ-007 req_we  input  1  1 = store, 0 = load.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  store data, right-aligned (SB uses [7:0], SH uses [15:0]).
REQ-010 req_funct3  input  3  RV32I size/sign code.
REQ-011 rsp_valid  output  1  one-cycle response strobe.
REQ-012 rsp_rdata  output  32  load result, extended to 32 bits; 0 for stores and errors.
REQ-013 rsp_err  output  1  qualified by rsp_valid; access rejected.
REQ-014 busy  output  1  stall request to the hazard logic; 1 whenever state is not IDLE.

Function
REQ-015 FSM states are IDLE, WAIT and RESP; req_ready=1 only in IDLE.
REQ-016 IDLE: on transfer, capture we/addr/wdata/funct3; go to WAIT with counter=LATENCY-1 if LATENCY>0, else to RESP.
REQ-017 WAIT: decrement the counter each cycle; on counter==0, go to RESP.
REQ-018 RESP: rsp_valid=1 for exactly one cycle, then return to IDLE; total latency is LATENCY+1 cycles from the accept edge to rsp_valid high.
REQ-019 The word index is addr[log2(DEPTH_WORDS)+1:2]; upper address bits are ignored, so accesses wrap modulo the memory size.
REQ-020 Loads: 000 LB and 100 LBU select the byte at addr[1:0]; 001 LH and 101 LHU select the half at addr[1]; 010 LW selects the whole word. LB/LH sign-extend; LBU/LHU zero-extend.
REQ-021 Stores: 000 SB, 001 SH and 010 SW write only the addressed byte lanes; other lanes are unchanged.
REQ-022 A store commits on the edge leaving RESP; a load samples the memory in RESP; a load accepted after a store therefore returns the new data.
REQ-023 Illegal funct3 (011, 110, 111, and 100/101 with we=1) gives rsp_err=1 and rsp_rdata=0, with no memory write.
REQ-024 req_valid while busy is ignored; the requester holds its request until req_ready.
REQ-025 rsp_rdata and rsp_err are 0 whenever rsp_valid=0.

Reset
REQ-026 Reset forces state=IDLE, counter=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0 and req_ready=1, asynchronously.
REQ-027 Reset during WAIT or RESP discards the pending access; no store commits and no response is issued.
REQ-028 Memory contents are not cleared by reset.

Configuration
REQ-029 With macro DMEM_MISALIGN_ERR_EN defined, a misaligned access (half with addr[0]=1, word with addr[1:0]!=0) gives rsp_err=1 and rsp_rdata=0, with no write, at normal latency.
REQ-030 Without DMEM_MISALIGN_ERR_EN, the offending low address bits are forced to 0 (half: addr[0]; word: addr[1:0]), the access completes normally, and rsp_err stays 0 for aligned-legal codes.

Verification
REQ-031 LATENCY=2: SW 0xDEADBEEF to 0x10, then LW 0x10 -> rsp_valid exactly 3 cycles after each accept; load returns 0xDEADBEEF with rsp_err=0.
REQ-032 After word 0x10=0xDEADBEEF: LB 0x13 -> 0xFFFFFFDE; LBU 0x13 -> 0x000000DE; LH 0x10 -> 0xFFFFBEEF; LHU 0x12 -> 0x0000DEAD.
REQ-033 SB 0x55 to 0x11 over 0xDEADBEEF, then LW 0x10 -> 0xDEAD55EF; SH 0x1234 to 0x12, then LW 0x10 -> 0x123455EF.
REQ-034 LW 0x12: with DMEM_MISALIGN_ERR_EN, rsp_err=1 and rdata=0; without it, the result equals LW 0x10.
REQ-035 Assert reset in the WAIT cycle of SW 0xAAAAAAAA to 0x20 -> no rsp_valid, busy=0 immediately; later LW 0x20 returns the prior contents.
REQ-036 DEPTH_WORDS=1024: SW 0x1 to 0x1000 aliases 0x0, so LW 0x0 -> 0x00000001; funct3=011 load -> rsp_err=1.
